// File: rtl/fetch_inst_queue_pkg.sv
// Shared frontend definitions for the fetch instruction queue: block geometry,
// the buffered-entry layout and the PC-to-slot helper.
package fetch_inst_queue_pkg;

   localparam int FETCH_BLK_INSTS = 16;
   localparam int INST_W          = 32;
   localparam int SLOT_W          = $clog2(FETCH_BLK_INSTS);
   localparam int BLK_W           = FETCH_BLK_INSTS * INST_W;
   localparam int PC_W            = 64;

   // One buffered fetch block: raw data, PC of slot 0, next slot to deliver
   // and the last slot that may be delivered (inclusive).
   typedef struct packed {
      logic [BLK_W-1:0]  data;
      logic [PC_W-1:0]   base_pc;
      logic [SLOT_W-1:0] head;
      logic [SLOT_W-1:0] end_idx;
   } fetch_blk_t;

   // Slot index of a PC within its 64-byte block; only the low 6 bits of the
   // byte offset matter, so the subtraction is done on those bits alone.
   function automatic logic [SLOT_W-1:0] slot_of(input logic [5:0] pc_lo,
                                                 input logic [5:0] base_lo);
      return SLOT_W'((pc_lo - base_lo) >> 2);
   endfunction

endpackage

// File: rtl/fetch_inst_queue_slot_sel.sv
// Per-lane slot selector: picks one instruction out of a fetch block and
// forms its PC from the block base.
module fiq_slot_sel
   import fetch_inst_queue_pkg::*;
(
   input  logic [BLK_W-1:0]  data,
   input  logic [PC_W-1:0]   base_pc,
   input  logic [SLOT_W-1:0] slot,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   pc
);

   // 16:1 instruction mux and slot-offset PC adder
   always_comb begin
      inst = data[slot*INST_W +: INST_W];
      pc   = base_pc + {{(PC_W-SLOT_W-2){1'b0}}, slot, 2'b00};
   end

endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling queue between fetch-block masking and decode. Buffers whole
// fetch blocks and drains them two instructions per cycle in program order,
// never crossing a block boundary within one cycle.
module fetch_inst_queue
   import fetch_inst_queue_pkg::*;
#(
   parameter int BLK_DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                blk_valid,
   output logic                blk_ready,
   input  logic [BLK_W-1:0]    blk_data,
   input  logic [PC_W-1:0]     blk_base_pc,
   input  logic [PC_W-1:0]     blk_start_pc,
   input  logic                blk_taken,
   input  logic [PC_W-1:0]     blk_trigger_pc,
   output logic [1:0]          out_valid,
   output logic [2*INST_W-1:0] out_inst,
   output logic [2*PC_W-1:0]   out_pc,
   input  logic                out_ready
);

   localparam int PTR_W = $clog2(BLK_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fetch_blk_t       mem_q [BLK_DEPTH];
   fetch_blk_t       mem_d [BLK_DEPTH];

   fetch_blk_t        head_blk;
   logic [SLOT_W-1:0] slot1;
   logic              lane0_vld, lane1_vld;
   logic [INST_W-1:0] inst0, inst1;
   logic [PC_W-1:0]   pc0, pc1;
   logic [SLOT_W-1:0] start_idx, end_idx;
   logic              accept, store, fire, retire;
   logic [SLOT_W:0]   new_head;
   logic              unused_pc_bits;

   // Only the in-block offset of the start/trigger PCs is meaningful
   assign unused_pc_bits = ^{blk_start_pc[PC_W-1:6], blk_trigger_pc[PC_W-1:6]};

   assign head_blk  = mem_q[rd_ptr_q];
   assign slot1     = head_blk.head + 1'b1;
   assign blk_ready = (cnt_q != CNT_W'(BLK_DEPTH));

   // Lane validity: lane1 only when the next slot is inside the same block span
   always_comb begin
      lane0_vld = (cnt_q != '0);
      lane1_vld = lane0_vld && (head_blk.head != {SLOT_W{1'b1}}) &&
                  (slot1 <= head_blk.end_idx);
      out_valid = {lane1_vld, lane0_vld};
   end

   fiq_slot_sel u_sel_lane0 (
      .data    (head_blk.data),
      .base_pc (head_blk.base_pc),
      .slot    (head_blk.head),
      .inst    (inst0),
      .pc      (pc0)
   );

   fiq_slot_sel u_sel_lane1 (
      .data    (head_blk.data),
      .base_pc (head_blk.base_pc),
      .slot    (slot1),
      .inst    (inst1),
      .pc      (pc1)
   );

   // Invalid lanes present zero so the outputs are clean after reset
   always_comb begin
      out_inst = {lane1_vld ? inst1 : '0, lane0_vld ? inst0 : '0};
      out_pc   = {lane1_vld ? pc1   : '0, lane0_vld ? pc0   : '0};
   end

   // Next-state: flush beats everything; otherwise drain the head and enqueue
   always_comb begin
      mem_d     = mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      start_idx = slot_of(blk_start_pc[5:0], blk_base_pc[5:0]);
      end_idx   = blk_taken ? slot_of(blk_trigger_pc[5:0], blk_base_pc[5:0])
                            : {SLOT_W{1'b1}};
      accept    = blk_valid && blk_ready && !flush;
      store     = accept && (end_idx >= start_idx);
      fire      = out_ready && lane0_vld && !flush;
      new_head  = {1'b0, head_blk.head} + (lane1_vld ? (SLOT_W+1)'(2) : (SLOT_W+1)'(1));
      retire    = fire && (new_head > {1'b0, head_blk.end_idx});
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (fire) begin
            if (retire) rd_ptr_d = rd_ptr_q + 1'b1;
            else        mem_d[rd_ptr_q].head = new_head[SLOT_W-1:0];
         end
         if (store) begin
            mem_d[wr_ptr_q] = '{data: blk_data, base_pc: blk_base_pc,
                                head: start_idx, end_idx: end_idx};
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         cnt_d = cnt_q + CNT_W'(store) - CNT_W'(retire);
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < BLK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         for (int i = 0; i < BLK_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: accepted blocks are expanded into
// expected output beats; a monitor pops and compares on each delivered beat.
module tb_fetch_inst_queue;

   localparam int DEPTH = 2;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic [63:0]  blk_base_pc = '0;
   logic [63:0]  blk_start_pc = '0;
   logic         blk_taken = 1'b0;
   logic [63:0]  blk_trigger_pc = '0;
   logic [1:0]   out_valid;
   logic [63:0]  out_inst;
   logic [127:0] out_pc;
   logic         out_ready = 1'b0;

   fetch_inst_queue #(.BLK_DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .flush          (flush),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .blk_data       (blk_data),
      .blk_base_pc    (blk_base_pc),
      .blk_start_pc   (blk_start_pc),
      .blk_taken      (blk_taken),
      .blk_trigger_pc (blk_trigger_pc),
      .out_valid      (out_valid),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          n;
      logic [31:0] i0, i1;
      logic [63:0] p0, p1;
      bit          last;
   } beat_t;

   beat_t exp_q[$];
   int    model_cnt = 0;
   int    n_pass = 0;
   int    n_total = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   function automatic int slot_of(input logic [63:0] pc, input logic [63:0] base);
      return int'(((pc - base) >> 2) & 64'hF);
   endfunction

   // Expand the block currently on the blk_* inputs into expected beats
   task automatic push_block();
      int s, e;
      s = slot_of(blk_start_pc, blk_base_pc);
      e = blk_taken ? slot_of(blk_trigger_pc, blk_base_pc) : 15;
      if (e < s) return;
      model_cnt++;
      for (int i = s; i <= e; i += 2) begin
         beat_t b;
         b.n    = (i + 1 <= e) ? 2 : 1;
         b.i0   = blk_data[32*i +: 32];
         b.p0   = blk_base_pc + 64'(4 * i);
         b.i1   = '0;
         b.p1   = '0;
         if (b.n == 2) begin
            b.i1 = blk_data[32*(i+1) +: 32];
            b.p1 = blk_base_pc + 64'(4 * (i + 1));
         end
         b.last = (i + 2 > e);
         exp_q.push_back(b);
      end
   endtask

   // One clock: note handshake before the edge, update model at the edge
   task automatic step();
      bit a, f;
      @(negedge clock);
      f = flush;
      a = blk_valid && blk_ready && !flush;
      @(posedge clock);
      if (f) begin
         exp_q.delete();
         model_cnt = 0;
      end else if (a) begin
         push_block();
      end
      #1;
   endtask

   task automatic set_blk(input logic [63:0] base, input int s, input int e, input bit tk);
      for (int i = 0; i < 16; i++) blk_data[32*i +: 32] = $urandom;
      blk_base_pc    = base;
      blk_start_pc   = base + 64'(4 * s);
      blk_taken      = tk;
      blk_trigger_pc = base + 64'(4 * e);
   endtask

   task automatic offer(input logic [63:0] base, input int s, input int e, input bit tk);
      set_blk(base, s, e, tk);
      blk_valid = 1'b1;
      step();
      blk_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // Monitor: compare lane validity and ready every cycle, contents on delivery
   always @(negedge clock) begin : mon
      logic [1:0] ev;
      beat_t      b;
      if (reset_n) begin
         ev = (exp_q.size() == 0) ? 2'b00 : ((exp_q[0].n == 2) ? 2'b11 : 2'b01);
         chk("out_valid", 128'(out_valid), 128'(ev));
         chk("blk_ready", 128'(blk_ready), 128'(model_cnt != DEPTH));
         if (out_ready && !flush && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("lane0_inst", 128'(out_inst[31:0]), 128'(b.i0));
            chk("lane0_pc",   128'(out_pc[63:0]),   128'(b.p0));
            if (b.n == 2) begin
               chk("lane1_inst", 128'(out_inst[63:32]), 128'(b.i1));
               chk("lane1_pc",   128'(out_pc[127:64]),  128'(b.p1));
            end
            if (b.last) model_cnt--;
         end
      end
   end

   initial begin
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_blk_ready", 128'(blk_ready), 128'(1));
      chk("rst_out_inst",  128'(out_inst),  128'(0));
      chk("rst_out_pc",    out_pc,          128'(0));
      @(posedge clock);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Full block, no taken branch
      out_ready = 1'b1;
      offer(64'h8000_0000, 0, 0, 1'b0);
      idle(10);

      // Mid-block start with taken branch: slots 5..8
      offer(64'h8000_0040, 5, 8, 1'b1);
      idle(4);

      // Odd span: slots 2..4
      offer(64'h8000_0080, 2, 4, 1'b1);
      idle(4);

      // Backpressure: three offers, only two fit
      out_ready = 1'b0;
      set_blk(64'h9000_0000, 0, 0, 1'b0);
      blk_valid = 1'b1;
      step();
      set_blk(64'h9000_0040, 3, 10, 1'b1);
      step();
      set_blk(64'h9000_0080, 1, 1, 1'b1);
      step();
      blk_valid = 1'b0;
      idle(2);
      out_ready = 1'b1;
      idle(20);

      // Flush while lane0 is at slot 6 of the first block, with a block offered
      offer(64'hA000_0000, 0, 0, 1'b0);
      offer(64'hA000_0040, 0, 0, 1'b0);
      idle(2);
      set_blk(64'hA000_0080, 0, 0, 1'b0);
      blk_valid = 1'b1;
      flush     = 1'b1;
      step();
      blk_valid = 1'b0;
      flush     = 1'b0;
      idle(3);

      // Degenerate block: trigger before start
      offer(64'hB000_0000, 7, 3, 1'b1);
      idle(3);

      // Asynchronous reset mid-drain
      offer(64'hC000_0000, 0, 0, 1'b0);
      idle(2);
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 128'(out_valid), 128'(0));
      chk("async_rst_blk_ready", 128'(blk_ready), 128'(1));
      exp_q.delete();
      model_cnt = 0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      idle(2);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         logic [63:0] base;
         base      = {$urandom, $urandom} & ~64'h3F;
         set_blk(base, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
         blk_valid = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      blk_valid = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Bounded drain of whatever remains
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) step();
      idle(2);
      chk("drain_done", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
